// File: rtl/reg_file_sb_if.sv
// Operand/writeback/issue bus of the scoreboarded register file.
// The slave modport is the register file; the master is the decode/issue/writeback side.
interface reg_file_sb_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  ready_o;
    logic                  write_enable_i;
    logic [ADDR_WIDTH-1:0] write_addr_i;
    logic [DATA_WIDTH-1:0] write_data_i;
    logic [ADDR_WIDTH-1:0] read_addr1_i;
    logic [ADDR_WIDTH-1:0] read_addr2_i;
    logic [DATA_WIDTH-1:0] read_data1_o;
    logic [DATA_WIDTH-1:0] read_data2_o;
    logic                  reserve_i;
    logic [ADDR_WIDTH-1:0] reserve_addr_i;
    logic                  busy1_o;
    logic                  busy2_o;
    logic [ADDR_WIDTH:0]   busy_count_o;

    modport slave (
        output ready_o,
        input  write_enable_i,
        input  write_addr_i,
        input  write_data_i,
        input  read_addr1_i,
        input  read_addr2_i,
        output read_data1_o,
        output read_data2_o,
        input  reserve_i,
        input  reserve_addr_i,
        output busy1_o,
        output busy2_o,
        output busy_count_o
    );

    modport master (
        input  ready_o,
        output write_enable_i,
        output write_addr_i,
        output write_data_i,
        output read_addr1_i,
        output read_addr2_i,
        input  read_data1_o,
        input  read_data2_o,
        output reserve_i,
        output reserve_addr_i,
        input  busy1_o,
        input  busy2_o,
        input  busy_count_o
    );
endinterface

// File: rtl/reg_file_sb.sv
// Parametrised integer register file with write-to-read bypass and a per-register
// busy scoreboard. After reset a sequencer zeroes one register per cycle before
// the file reports ready; writes and reserves arriving during that sweep are dropped.
module reg_file_sb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG   = 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    reg_file_sb_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_INDEX = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] clear_index;
    logic [DEPTH-1:0]      busy;
    logic [ADDR_WIDTH:0]   busy_count;
    logic                  ready;
    logic [DATA_WIDTH-1:0] regs [DEPTH];

    logic write_ok;
    logic reserve_ok;
    logic count_up;
    logic count_down;

    // Qualify the strobes: nothing takes effect during the clear sweep or on the hardwired zero register.
    always_comb begin
        write_ok   = (state == ST_RUN) && bus.write_enable_i &&
                     !((ZERO_REG != 0) && (bus.write_addr_i == '0));
        reserve_ok = (state == ST_RUN) && bus.reserve_i &&
                     !((ZERO_REG != 0) && (bus.reserve_addr_i == '0));
        count_up   = reserve_ok && !busy[bus.reserve_addr_i];
        count_down = write_ok && busy[bus.write_addr_i] &&
                     !(reserve_ok && (bus.reserve_addr_i == bus.write_addr_i));
    end

    // Sequencer, scoreboard and busy population count; a reserve overrides a same-cycle release.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= ST_INIT;
            clear_index <= '0;
            busy        <= '0;
            busy_count  <= '0;
            ready       <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    clear_index <= clear_index + ADDR_WIDTH'(1);
                    if (clear_index == LAST_INDEX) begin
                        state <= ST_RUN;
                        ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (write_ok) begin
                        busy[bus.write_addr_i] <= 1'b0;
                    end
                    if (reserve_ok) begin
                        busy[bus.reserve_addr_i] <= 1'b1;
                    end
                    busy_count <= busy_count + (ADDR_WIDTH+1)'(count_up)
                                             - (ADDR_WIDTH+1)'(count_down);
                end
                default: begin
                    state <= ST_INIT;
                end
            endcase
        end
    end

    // Register storage is unreset; the sweep zeroes it, then writeback updates it.
    always_ff @(posedge clk_i) begin
        if (state == ST_INIT) begin
            regs[clear_index] <= '0;
        end else if (write_ok) begin
            regs[bus.write_addr_i] <= bus.write_data_i;
        end
    end

    function automatic logic [DATA_WIDTH-1:0] read_value(input logic [ADDR_WIDTH-1:0] addr);
        if (state != ST_RUN) begin
            return '0;
        end
        if ((ZERO_REG != 0) && (addr == '0)) begin
            return '0;
        end
        if ((BYPASS != 0) && write_ok && (bus.write_addr_i == addr)) begin
            return bus.write_data_i;
        end
        return regs[addr];
    endfunction

    function automatic logic read_busy(input logic [ADDR_WIDTH-1:0] addr);
        if (state != ST_RUN) begin
            return 1'b0;
        end
        if ((ZERO_REG != 0) && (addr == '0)) begin
            return 1'b0;
        end
        if ((BYPASS != 0) && write_ok && (bus.write_addr_i == addr)) begin
            return 1'b0;
        end
        return busy[addr];
    endfunction

    // Zero-latency operand reads with optional forwarding of the in-flight writeback.
    always_comb begin
        bus.read_data1_o = read_value(bus.read_addr1_i);
        bus.read_data2_o = read_value(bus.read_addr2_i);
        bus.busy1_o      = read_busy(bus.read_addr1_i);
        bus.busy2_o      = read_busy(bus.read_addr2_i);
    end

    assign bus.ready_o      = ready;
    assign bus.busy_count_o = busy_count;
endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
Parametrised successor to the core's integer register file. Adds configurable data width and depth, write-to-read bypass, and a per-register busy scoreboard for in-flight producers. After reset, a sequencer clears every register, so no initial block is needed. Sits in the decode stage: decode reads operands and busy flags, issue reserves destinations, writeback writes and releases.

Parameters:
DATA_WIDTH, 32, register width in bits.
ADDR_WIDTH, 5, register index width; DEPTH = 2**ADDR_WIDTH registers.
BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return stored value only.
ZERO_REG, 1, 1 = register 0 hardwired to zero, never written, never busy.

Ports:
clk_i  in  1  clock; all state updates on rising edge.
rst_i  in  1  asynchronous, active-low reset.
ready_o  out  1  high once the post-reset clear sequence completes.
write_enable_i  in  1  writeback strobe.
write_addr_i  in  ADDR_WIDTH  writeback register index.
write_data_i  in  DATA_WIDTH  writeback data.
read_addr1_i  in  ADDR_WIDTH  operand 1 index.
read_addr2_i  in  ADDR_WIDTH  operand 2 index.
read_data1_o  out  DATA_WIDTH  operand 1 data, combinational.
read_data2_o  out  DATA_WIDTH  operand 2 data, combinational.
reserve_i  in  1  issue strobe: mark destination busy.
reserve_addr_i  in  ADDR_WIDTH  destination index to reserve.
busy1_o  out  1  operand 1 register has a pending producer.
busy2_o  out  1  operand 2 register has a pending producer.
busy_count_o  out  ADDR_WIDTH+1  number of registers currently busy.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - state=INIT, clear counter=0, busy vector all 0.
  - ready_o=0, busy_count_o=0.
  - Register contents are not reset directly; the clear sequence zeroes them.
- INIT state:
  - Each cycle, clears register[counter] and increments counter.
  - After clearing index DEPTH-1, moves to RUN. ready_o=1 in the cycle after the last clear, i.e. DEPTH cycles after reset release.
  - write_enable_i and reserve_i are ignored (dropped, not queued).
  - read_data*_o=0 and busy*_o=0 while in INIT.
- RUN state:
  - Write: on an edge with write_enable_i=1, register[write_addr_i] <= write_data_i and busy[write_addr_i] <= 0. Skipped when ZERO_REG=1 and addr=0.
  - Reserve: on an edge with reserve_i=1, busy[reserve_addr_i] <= 1. Ignored for addr 0 when ZERO_REG=1.
  - Write and reserve to the same index in the same cycle: data is written, and busy ends at 1 because reserve wins (a new producer has been issued).
  - Read: read_data*_o = register[addr], combinational, zero latency. Returns 0 for addr 0 when ZERO_REG=1.
  - Bypass (BYPASS=1), for write_enable_i=1 and write_addr_i==read_addr*_i (valid index):
    - read_data*_o = write_data_i in the same cycle.
    - busy*_o = 0 in the same cycle, even if a reserve to that index is also present.
  - Bypass off (BYPASS=0): new data is visible the cycle after the write; busy*_o reflects the registered busy vector only.
  - Both read ports may address the same register; both return identical data and busy.
  - busy_count_o is the registered population count of the busy vector. Updated with the vector: +1 for reserve of a non-busy register, -1 for release of a busy register, net 0 when both happen. Never exceeds DEPTH (or DEPTH-1 when ZERO_REG=1).
  - Releasing a non-busy register or reserving a busy one: no error; the vector simply holds its value.
- Reset asserted mid-RUN: immediately returns to INIT, clears busy, drops ready_o, and the full clear sequence repeats.

Test Plan:
- Release reset with defaults -> ready_o=0 for exactly 32 cycles, then 1. Every register reads 0x00000000. write_enable_i=1 to x5=0xDEAD during INIT is dropped, so x5 reads 0 afterwards.
- RUN: write x7=0x12345678, read_addr1_i=7 in the same cycle -> read_data1_o=0x12345678 in that cycle with BYPASS=1. With BYPASS=0 -> old value 0 that cycle, 0x12345678 the next.
- Write x0=0xFFFFFFFF and reserve x0 -> read_data1_o=0 and busy1_o=0. busy_count_o stays 0.
- Reserve x3, x4 -> busy_count_o=2, busy1_o=1 for x3. Writeback x3 -> busy_count_o=1. Simultaneous write and reserve of x4 -> x4 stays busy, count stays 1.
- Reserve all of x1..x31 -> busy_count_o=31. Assert rst_i=0 mid-run -> busy_count_o=0 and ready_o=0 immediately, and the clear sequence repeats.
- DATA_WIDTH=64, ADDR_WIDTH=3 -> ready_o after 8 cycles. Write x7=0x0123456789ABCDEF reads back intact on both ports.
